fetch_prefetch_buffer: RTL and testbench
========================================

// Module: fetch_prefetch_buffer
// PURPOSE
//  Sits directly upstream of instruction fetch. Streams sequential instruction words from instruction memory into a small in-order queue.
//  Hands {pc, inst} pairs to instruction fetch over a valid/ready interface.
//  Redirect (branch taken / flush) clears the queue, discards in-flight responses and restarts fetch at a new PC.
// PARAMETERS
//  DEPTH     4        queue entries; also the cap on (queued + in-flight) requests; power of 2, >=2
//  XLEN      32       address/data width
//  RESET_PC  32'h0    fetch address after reset
// PORTS
//  clk             in   1     single clock, rising edge
//  reset           in   1     synchronous, active-high reset
//  redirect_valid  in   1     flush queue and restart fetch at redirect_pc
//  redirect_pc     in   XLEN  new fetch address; bits[1:0] ignored (forced 0)
//  mem_req_valid   out  1     instruction memory read request
//  mem_req_ready   in   1     memory accepts request this cycle
//  mem_req_addr    out  XLEN  word-aligned request address
//  mem_rsp_valid   in   1     read data returned; in order, <=1/cycle, >=1 cycle after accept, no backpressure
//  mem_rsp_data    in   XLEN  instruction word
//  if_valid        out  1     queue head valid toward instruction fetch
//  if_ready        in   1     instruction fetch consumes head
//  if_pc           out  XLEN  PC of head instruction
//  if_inst         out  XLEN  head instruction word
// BEHAVIOUR
//  - Reset (sync, active-high): queue empty; out_cnt=0; drop_cnt=0; fetch_pc=rsp_pc=RESET_PC.
//    mem_req_valid=0 and if_valid=0 during the reset cycle and the next cycle. if_pc/if_inst=0 while empty.
//  - Credit: mem_req_valid = !reset && !redirect_valid && (q_cnt + out_cnt) < DEPTH. mem_req_addr = fetch_pc.
//  - req_fire = mem_req_valid & mem_req_ready: fetch_pc += 4 (wraps modulo 2^XLEN); out_cnt++.
//  - mem_rsp_valid: out_cnt--.
//    If drop_cnt>0: discard the response, drop_cnt--.
//    Else: push {rsp_pc, mem_rsp_data}, rsp_pc += 4.
//    mem_rsp_valid with out_cnt==0 is a protocol error: assertion fires, response ignored.
//  - Pop: if_valid & if_ready removes the head.
//  - Pushed data is visible on if_* the next cycle (1-cycle rsp->if latency, no bypass).
//  - Push and pop in the same cycle are both honoured. Credit rule guarantees no overflow, so no full stall is needed.
//  - Redirect cycle:
//    queue cleared; if_valid forced 0 (a pop that cycle is ignored);
//    mem_req_valid forced 0 (valid may drop without ready only here);
//    fetch_pc = rsp_pc = {redirect_pc[XLEN-1:2], 2'b00};
//    drop_cnt = out_cnt - mem_rsp_valid (the response arriving this cycle is discarded too).
//    Requests resume the next cycle.
//  - Back-to-back redirects: each one re-applies the rule above. drop_cnt always equals the number of stale in-flight requests.
//  - Redirect together with reset: reset wins.
//  - Invariants (assert): q_cnt + out_cnt <= DEPTH; drop_cnt <= out_cnt.
//  - Counter widths: $clog2(DEPTH+1) bits.
// STRUCTURE
//  - riscv_pkg: XLEN, RESET_PC, typedef struct packed {logic [XLEN-1:0] pc; logic [XLEN-1:0] inst;} fetch_entry_t.
//  - Sub-module fetch_fifo: DEPTH x fetch_entry_t synchronous FIFO with push, pop, clear, count, head.
//    Pointers wrap modulo DEPTH.
//  - Top level holds fetch_pc, rsp_pc, out_cnt, drop_cnt and the credit/redirect logic.
// TESTING
//  1. Reset release, memory ready=1, latency 1, if_ready=1
//     -> requests at 0x0,0x4,0x8,...; if_pc 0x0 appears 2 cycles after first accept; one instruction per cycle thereafter.
//  2. if_ready=0, memory always ready
//     -> exactly DEPTH=4 requests issued (0x0..0xC), then mem_req_valid=0.
//     -> on if_ready=1, one new request per pop.
//  3. Latency-3 memory, 3 requests in flight, redirect to 0x103
//     -> next request addr 0x100; the 3 stale responses are dropped; first if_pc=0x100.
//  4. Redirect in the same cycle as mem_rsp_valid with out_cnt=2 -> drop_cnt=1; only the next response is dropped.
//  5. Two redirects on consecutive cycles (0x40 then 0x80) -> no entry with pc 0x40 is ever presented; first if_pc=0x80.
//  6. fetch_pc=0xFFFF_FFFC -> next request addr 0x0 (wrap).
//     Reset asserted mid-stream -> all counters cleared; restart at RESET_PC.

Source files
------------

// File: rtl/fetch_prefetch_buffer_pkg.sv
// Shared constants, the queue entry type and PC helpers for the fetch prefetch buffer.
package fetch_prefetch_buffer_pkg;

  localparam int              XLEN             = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP          = 32'h0000_0004;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_prefetch_buffer_if.sv
// Memory request/response channel and the instruction-fetch handoff channel of the prefetch buffer.
interface fetch_prefetch_buffer_if;
  import fetch_prefetch_buffer_pkg::*;

  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_rsp_valid;
  logic [XLEN-1:0] mem_rsp_data;
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_inst;

  // master is the prefetch buffer itself; slave is the memory + fetch side.
  modport master (
    output mem_req_valid, mem_req_addr, if_valid, if_pc, if_inst,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, if_ready
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, if_valid, if_pc, if_inst,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, if_ready
  );

endinterface

// File: rtl/fetch_prefetch_buffer_chk.sv
// Protocol and credit-invariant checks for the fetch prefetch buffer.
module fetch_prefetch_buffer_chk #(
  parameter int DEPTH = 4
) (
  input logic                       i_clk,
  input logic                       i_reset,
  input logic                       i_rsp_valid,
  input logic [$clog2(DEPTH+1)-1:0] i_out_cnt,
  input logic [$clog2(DEPTH+1)-1:0] i_drop_cnt,
  input logic [$clog2(DEPTH+1)-1:0] i_q_cnt
);

  localparam int          CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  a_rsp_has_request: assert property (@(posedge i_clk) disable iff (i_reset)
    !(i_rsp_valid && (i_out_cnt == '0)))
    else $error("memory response arrived with no request in flight");

  a_credit_bound: assert property (@(posedge i_clk) disable iff (i_reset)
    (({1'b0, i_q_cnt} + {1'b0, i_out_cnt}) <= DEPTH_C))
    else $error("queued plus in-flight requests exceed DEPTH");

  a_drop_bound: assert property (@(posedge i_clk) disable iff (i_reset)
    (i_drop_cnt <= i_out_cnt))
    else $error("drop count exceeds in-flight count");

endmodule

// File: rtl/fetch_prefetch_buffer_fifo.sv
// In-order queue of {pc, inst} entries with push, pop, clear, occupancy count and head view.
module fetch_prefetch_buffer_fifo
  import fetch_prefetch_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_clear,
  input  logic                           i_push,
  input  logic                           i_pop,
  input  fetch_entry_t                   i_data,
  output fetch_entry_t                   o_head,
  output logic [$clog2(DEPTH+1)-1:0]     o_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_cnt;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign w_push_ok = i_push && !i_clear && !i_reset;
  assign w_pop_ok  = i_pop && (r_cnt != '0);

  // Pointers and occupancy; DEPTH is a power of two so the pointers wrap on their own.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_cnt <= r_cnt + CW'(w_push_ok) - CW'(w_pop_ok);
    end
  end

  // Entry storage; contents are only meaningful between push and pop.
  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  assign o_head  = (r_cnt != '0) ? r_mem[r_rd_ptr] : '0;
  assign o_count = r_cnt;

endmodule

// File: rtl/fetch_prefetch_buffer.sv
// Sequential instruction prefetcher: credit-limited memory requests, in-order queue toward fetch, redirect flush.
module fetch_prefetch_buffer
  import fetch_prefetch_buffer_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_redirect_valid,
  input  logic [XLEN-1:0]         i_redirect_pc,
  fetch_prefetch_buffer_if.master io_bus
);

  localparam int            CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_rsp_pc;
  logic [CW-1:0]   r_out_cnt;
  logic [CW-1:0]   r_drop_cnt;
  logic            r_reset_d;

  logic [CW-1:0]   w_q_cnt;
  logic [XLEN-1:0] w_redirect_pc;
  logic            w_credit;
  logic            w_req_valid;
  logic            w_req_fire;
  logic            w_rsp_accept;
  logic            w_push;
  logic            w_if_valid;
  logic            w_pop;
  fetch_entry_t    w_push_entry;
  fetch_entry_t    w_head;

  assign w_redirect_pc = align_pc(i_redirect_pc);

  // Every queued entry and every outstanding request holds one of DEPTH slots, so the queue never overflows.
  assign w_credit    = ({1'b0, w_q_cnt} + {1'b0, r_out_cnt}) < DEPTH_C;
  assign w_req_valid = !i_reset && !r_reset_d && !i_redirect_valid && w_credit;
  assign w_req_fire  = w_req_valid && io_bus.mem_req_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign w_rsp_accept = io_bus.mem_rsp_valid && (r_out_cnt != '0);
  assign w_push       = w_rsp_accept && (r_drop_cnt == '0) && !i_redirect_valid;
  assign w_push_entry = '{pc: r_rsp_pc, inst: io_bus.mem_rsp_data};

  assign w_if_valid = (w_q_cnt != '0) && !i_reset && !i_redirect_valid;
  assign w_pop      = w_if_valid && io_bus.if_ready;

  // Fetch/response PCs plus the in-flight and stale-response counters.
  always_ff @(posedge i_clk) begin
    r_reset_d <= i_reset;
    if (i_reset) begin
      r_fetch_pc <= RESET_PC;
      r_rsp_pc   <= RESET_PC;
      r_out_cnt  <= '0;
      r_drop_cnt <= '0;
    end else if (i_redirect_valid) begin
      r_fetch_pc <= w_redirect_pc;
      r_rsp_pc   <= w_redirect_pc;
      r_out_cnt  <= r_out_cnt - CW'(w_rsp_accept);
      r_drop_cnt <= r_out_cnt - CW'(w_rsp_accept);
    end else begin
      if (w_req_fire) begin
        r_fetch_pc <= r_fetch_pc + PC_STEP;
      end
      if (w_push) begin
        r_rsp_pc <= r_rsp_pc + PC_STEP;
      end
      r_out_cnt <= r_out_cnt + CW'(w_req_fire) - CW'(w_rsp_accept);
      if (w_rsp_accept && (r_drop_cnt != '0)) begin
        r_drop_cnt <= r_drop_cnt - ONE_C;
      end
    end
  end

  fetch_prefetch_buffer_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (i_redirect_valid),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_push_entry),
    .o_head  (w_head),
    .o_count (w_q_cnt)
  );

  fetch_prefetch_buffer_chk #(
    .DEPTH (DEPTH)
  ) u_chk (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_rsp_valid(io_bus.mem_rsp_valid),
    .i_out_cnt  (r_out_cnt),
    .i_drop_cnt (r_drop_cnt),
    .i_q_cnt    (w_q_cnt)
  );

  assign io_bus.mem_req_valid = w_req_valid;
  assign io_bus.mem_req_addr  = r_fetch_pc;
  assign io_bus.if_valid      = w_if_valid;
  assign io_bus.if_pc         = w_head.pc;
  assign io_bus.if_inst       = w_head.inst;

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Directed bench for fetch_prefetch_buffer with a fixed-latency in-order instruction memory model.
module tb_fetch_prefetch_buffer;
  import fetch_prefetch_buffer_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        mem_ready = 1'b0;
  logic        if_ready = 1'b0;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data = 32'h0;

  int total = 0;
  int bad = 0;
  int lat = 1;
  int n40 = 0;

  logic [31:0] pend_addr[$];
  int          pend_age[$];
  logic [31:0] log_pc[$];
  logic [31:0] log_inst[$];
  logic [31:0] req_log[$];

  fetch_prefetch_buffer_if bus();

  assign bus.mem_req_ready = mem_ready;
  assign bus.if_ready      = if_ready;
  assign bus.mem_rsp_valid = rsp_valid;
  assign bus.mem_rsp_data  = rsp_data;

  fetch_prefetch_buffer #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_redirect_valid(redirect_valid),
    .i_redirect_pc   (redirect_pc),
    .io_bus          (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h1300_0013;
  endfunction

  function automatic logic [31:0] pc_at(input int i);
    if (i < log_pc.size()) return log_pc[i];
    return 32'hxxxx_xxxx;
  endfunction

  function automatic logic [31:0] inst_at(input int i);
    if (i < log_inst.size()) return log_inst[i];
    return 32'hxxxx_xxxx;
  endfunction

  function automatic logic [31:0] req_at(input int i);
    if (i < req_log.size()) return req_log[i];
    return 32'hxxxx_xxxx;
  endfunction

  // Memory model: a response is driven in the cycle 'lat' cycles after its accept cycle, in order.
  always @(negedge clk) begin
    if (reset) begin
      pend_addr.delete();
      pend_age.delete();
      rsp_valid = 1'b0;
      rsp_data  = 32'h0;
    end else begin
      foreach (pend_age[k]) pend_age[k] = pend_age[k] + 1;
      if (pend_age.size() > 0 && pend_age[0] >= lat) begin
        rsp_valid = 1'b1;
        rsp_data  = inst_of(pend_addr[0]);
        void'(pend_addr.pop_front());
        void'(pend_age.pop_front());
      end else begin
        rsp_valid = 1'b0;
        rsp_data  = 32'h0;
      end
      if (bus.mem_req_valid && bus.mem_req_ready) begin
        pend_addr.push_back(bus.mem_req_addr);
        pend_age.push_back(0);
      end
    end
  end

  // Records every accepted request and every instruction handed to fetch.
  always @(negedge clk) begin
    if (bus.if_valid && bus.if_ready) begin
      log_pc.push_back(bus.if_pc);
      log_inst.push_back(bus.if_inst);
    end
    if (bus.mem_req_valid && bus.mem_req_ready) req_log.push_back(bus.mem_req_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic reset_dut();
    step();
    reset = 1'b1;
    redirect_valid = 1'b0;
    mid();
    step();
    mid();
    chk("rst_req_valid", {31'h0, bus.mem_req_valid}, 32'h0);
    chk("rst_if_valid", {31'h0, bus.if_valid}, 32'h0);
    chk("rst_if_pc", bus.if_pc, 32'h0);
    chk("rst_if_inst", bus.if_inst, 32'h0);
    step();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: streaming, latency 1
    lat = 1; mem_ready = 1'b1; if_ready = 1'b1;
    reset_dut();
    mid();
    chk("t1_hold_req_valid", {31'h0, bus.mem_req_valid}, 32'h0);
    chk("t1_hold_if_valid", {31'h0, bus.if_valid}, 32'h0);
    step(); mid();
    chk("t1_req0_valid", {31'h0, bus.mem_req_valid}, 32'h1);
    chk("t1_req0_addr", bus.mem_req_addr, 32'h0);
    step(); mid();
    chk("t1_req1_addr", bus.mem_req_addr, 32'h4);
    chk("t1_early_if_valid", {31'h0, bus.if_valid}, 32'h0);
    step(); mid();
    chk("t1_if_valid", {31'h0, bus.if_valid}, 32'h1);
    chk("t1_if_pc0", bus.if_pc, 32'h0);
    chk("t1_if_inst0", bus.if_inst, inst_of(32'h0));
    chk("t1_req2_addr", bus.mem_req_addr, 32'h8);
    step(); mid();
    chk("t1_if_pc1", bus.if_pc, 32'h4);
    chk("t1_if_inst1", bus.if_inst, inst_of(32'h4));
    step(); mid();
    chk("t1_if_pc2", bus.if_pc, 32'h8);

    // 2: fetch stalled, credit limit
    reset_dut();
    if_ready = 1'b0;
    req_log.delete();
    repeat (10) begin mid(); step(); end
    mid();
    chk("t2_req_count", req_log.size(), 32'd4);
    chk("t2_req_a0", req_at(0), 32'h0);
    chk("t2_req_a1", req_at(1), 32'h4);
    chk("t2_req_a2", req_at(2), 32'h8);
    chk("t2_req_a3", req_at(3), 32'hC);
    chk("t2_full_req_valid", {31'h0, bus.mem_req_valid}, 32'h0);
    chk("t2_head_pc", bus.if_pc, 32'h0);
    step(); if_ready = 1'b1; mid();
    chk("t2_pop_cycle_req_valid", {31'h0, bus.mem_req_valid}, 32'h0);
    step(); if_ready = 1'b0; mid();
    chk("t2_refill_req_valid", {31'h0, bus.mem_req_valid}, 32'h1);
    chk("t2_refill_addr", bus.mem_req_addr, 32'h10);
    chk("t2_head_after_pop", bus.if_pc, 32'h4);
    step(); mid();
    chk("t2_single_refill", {31'h0, bus.mem_req_valid}, 32'h0);
    chk("t2_req_count2", req_log.size(), 32'd5);

    // 3: latency 3, redirect with three requests outstanding
    lat = 3; if_ready = 1'b1;
    reset_dut();
    repeat (4) begin mid(); step(); end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    log_pc.delete(); log_inst.delete();
    mid();
    chk("t3_redir_req_valid", {31'h0, bus.mem_req_valid}, 32'h0);
    chk("t3_redir_if_valid", {31'h0, bus.if_valid}, 32'h0);
    step(); redirect_valid = 1'b0; mid();
    chk("t3_resume_valid", {31'h0, bus.mem_req_valid}, 32'h1);
    chk("t3_resume_addr", bus.mem_req_addr, 32'h100);
    step(); mid();
    chk("t3_next_addr", bus.mem_req_addr, 32'h104);
    repeat (6) begin step(); mid(); end
    chk("t3_first_pc", pc_at(0), 32'h100);
    chk("t3_first_inst", inst_at(0), inst_of(32'h100));
    chk("t3_second_pc", pc_at(1), 32'h104);

    // 4: redirect coincides with a response, two outstanding
    lat = 2;
    reset_dut();
    repeat (3) begin mid(); step(); end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    log_pc.delete(); log_inst.delete();
    mid();
    chk("t4_redir_req_valid", {31'h0, bus.mem_req_valid}, 32'h0);
    step(); redirect_valid = 1'b0; mid();
    chk("t4_resume_addr", bus.mem_req_addr, 32'h200);
    repeat (5) begin step(); mid(); end
    chk("t4_first_pc", pc_at(0), 32'h200);
    chk("t4_first_inst", inst_at(0), inst_of(32'h200));

    // 5: back-to-back redirects
    lat = 1;
    reset_dut();
    repeat (5) begin mid(); step(); end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
    log_pc.delete(); log_inst.delete();
    mid(); step();
    redirect_pc = 32'h0000_0080;
    mid();
    chk("t5_second_redir_req_valid", {31'h0, bus.mem_req_valid}, 32'h0);
    step(); redirect_valid = 1'b0; mid();
    chk("t5_resume_addr", bus.mem_req_addr, 32'h80);
    repeat (6) begin step(); mid(); end
    chk("t5_first_pc", pc_at(0), 32'h80);
    chk("t5_first_inst", inst_at(0), inst_of(32'h80));
    chk("t5_second_pc", pc_at(1), 32'h84);
    n40 = 0;
    foreach (log_pc[k]) if (log_pc[k][31:6] == 26'h1) n40++;
    chk("t5_no_0x40_entries", n40, 32'd0);

    // 6: address wrap, then reset mid-stream
    step();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    log_pc.delete(); log_inst.delete();
    mid(); step();
    redirect_valid = 1'b0;
    mid();
    chk("t6_top_addr", bus.mem_req_addr, 32'hFFFF_FFFC);
    step(); mid();
    chk("t6_wrap_valid", {31'h0, bus.mem_req_valid}, 32'h1);
    chk("t6_wrap_addr", bus.mem_req_addr, 32'h0);
    repeat (3) begin step(); mid(); end
    chk("t6_top_pc", pc_at(0), 32'hFFFF_FFFC);
    chk("t6_wrap_pc", pc_at(1), 32'h0);
    chk("t6_wrap_inst", inst_at(1), inst_of(32'h0));
    step();
    reset = 1'b1;
    log_pc.delete(); log_inst.delete();
    mid();
    chk("t6_rst_req_valid", {31'h0, bus.mem_req_valid}, 32'h0);
    chk("t6_rst_if_valid", {31'h0, bus.if_valid}, 32'h0);
    step(); reset = 1'b0; mid();
    chk("t6_post_req_valid", {31'h0, bus.mem_req_valid}, 32'h0);
    chk("t6_post_if_valid", {31'h0, bus.if_valid}, 32'h0);
    chk("t6_post_if_pc", bus.if_pc, 32'h0);
    chk("t6_post_if_inst", bus.if_inst, 32'h0);
    step(); mid();
    chk("t6_restart_valid", {31'h0, bus.mem_req_valid}, 32'h1);
    chk("t6_restart_addr", bus.mem_req_addr, 32'h0);
    repeat (4) begin step(); mid(); end
    chk("t6_restart_first_pc", pc_at(0), 32'h0);
    chk("t6_restart_first_inst", inst_at(0), inst_of(32'h0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
